// File: rtl/mem_bus_interface.sv
// MEM-stage bus bridge: one-entry posted write buffer with read-hit
// forwarding, a handshaked variable-latency memory bus and a pipeline stall.
//
// Ports:
//   clk, rst          clock; asynchronous active-low reset
//   mem_read/write    MEM-stage load/store request (write wins if both set)
//   addr, wdata       byte address (addr[1:0] ignored) and store data
//   rdata             load data toward MEM/WB
//   stall             freeze request for PC and the pipeline registers
//   bus_err           one-cycle pulse when a bus access times out
//   bus_req/we/addr/wdata  request toward backing memory
//   bus_rdata/ack     response from backing memory (ack is one cycle)
module mem_bus_interface #(
    parameter int unsigned TIMEOUT_CYC = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        stall,
    output logic        bus_err,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    input  logic [31:0] bus_rdata,
    input  logic        bus_ack
);

    typedef enum logic [1:0] {
        IDLE,
        W_BUSY,
        R_BUSY,
        R_DONE
    } state_e;

    localparam logic [7:0] TMO = 8'(TIMEOUT_CYC);

    state_e      state_q, state_d;
    logic        wb_valid_q, wb_valid_d;
    logic [29:0] wb_addr_q, wb_addr_d;
    logic [31:0] wb_data_q, wb_data_d;
    logic [29:0] rd_addr_q, rd_addr_d;
    logic [31:0] rd_q, rd_d;
    logic [7:0]  cnt_q, cnt_d;

    logic busy;
    logic tmo;
    logic ack;
    logic is_wr;
    logic is_rd;
    logic hit;
    logic rd_miss;
    logic drain_ack;
    logic wr_take;
    logic enter_busy;
    logic unused_addr;

    assign unused_addr = ^addr[1:0];

    assign busy = (state_q == W_BUSY) ||
                  (state_q == R_BUSY);

    // The timeout cycle itself is no longer a bus cycle: the request is
    // withdrawn, so a late ack in that cycle must not be taken.
    assign tmo = busy && (cnt_q == TMO);
    assign ack = busy && !tmo && bus_ack;

    assign is_wr   = mem_write;
    assign is_rd   = mem_read && !mem_write;
    assign hit     = wb_valid_q &&
                     (wb_addr_q == addr[31:2]);
    assign rd_miss = is_rd && !hit;

    assign drain_ack = (state_q == W_BUSY) && ack;

    // A store lands in the buffer when it is empty, or on the very edge
    // that the previous buffered store is acknowledged.
    assign wr_take = is_wr &&
                     (!wb_valid_q || drain_ack);

    always_comb begin
        state_d    = state_q;
        wb_valid_d = wb_valid_q;
        wb_addr_d  = wb_addr_q;
        wb_data_d  = wb_data_q;
        rd_addr_d  = rd_addr_q;
        rd_d       = rd_q;
        cnt_d      = cnt_q;

        if (wr_take) begin
            wb_valid_d = 1'b1;
            wb_addr_d  = addr[31:2];
            wb_data_d  = wdata;
        end

        unique case (state_q)
            IDLE: begin
                if (wb_valid_q) begin
                    state_d = W_BUSY;
                end else if (rd_miss) begin
                    state_d = R_BUSY;
                end
            end
            W_BUSY: begin
                if (tmo) begin
                    wb_valid_d = 1'b0;
                    state_d    = IDLE;
                end else if (ack) begin
                    if (!wr_take) begin
                        wb_valid_d = 1'b0;
                    end
                    state_d = rd_miss ? R_BUSY : IDLE;
                end
            end
            R_BUSY: begin
                if (tmo) begin
                    rd_d    = '0;
                    state_d = R_DONE;
                end else if (ack) begin
                    rd_d    = bus_rdata;
                    state_d = R_DONE;
                end
            end
            R_DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        enter_busy = (state_d != state_q) &&
                     ((state_d == W_BUSY) ||
                      (state_d == R_BUSY));

        // The read address is latched so the bus stays stable even if
        // the upstream address wiggles while frozen.
        if (enter_busy && (state_d == R_BUSY)) begin
            rd_addr_d = addr[31:2];
        end

        if (enter_busy || !busy) begin
            cnt_d = '0;
        end else if (!ack && !tmo) begin
            cnt_d = cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            wb_valid_q <= 1'b0;
            wb_addr_q  <= '0;
            wb_data_q  <= '0;
            rd_addr_q  <= '0;
            rd_q       <= '0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            wb_valid_q <= wb_valid_d;
            wb_addr_q  <= wb_addr_d;
            wb_data_q  <= wb_data_d;
            rd_addr_q  <= rd_addr_d;
            rd_q       <= rd_d;
            cnt_q      <= cnt_d;
        end
    end

    // Bus signals decode only registered state, so an asynchronous
    // reset removes the request without waiting for an edge.
    assign bus_req = busy && !tmo;
    assign bus_we  = (state_q == W_BUSY) && !tmo;
    assign bus_err = tmo;

    always_comb begin
        bus_addr  = '0;
        bus_wdata = '0;
        if (state_q == W_BUSY) begin
            bus_addr  = {wb_addr_q, 2'b00};
            bus_wdata = wb_data_q;
        end else if (state_q == R_BUSY) begin
            bus_addr  = {rd_addr_q, 2'b00};
        end
    end

    assign rdata = hit ? wb_data_q : rd_q;

    // Store stall releases combinationally on the drain ack so the new
    // store and the buffer hand-over share one edge.
    assign stall = rst &&
                   ((is_wr && wb_valid_q && !drain_ack) ||
                    (rd_miss && (state_q != R_DONE)));

endmodule

// File: doc/mem_bus_interface.md
Name: mem_bus_interface

Overview:
- Sits directly downstream of the EX/MEM pipeline register, in the MEM stage of the 5-stage MIPS datapath.
- Replaces the zero-latency data memory with a handshaked, variable-latency backing-memory bus.
- Contains a one-entry posted write buffer with read-hit forwarding.
- Drives a global stall that freezes PC, IF/ID, ID/EX, EX/MEM and MEM/WB while a bus access is outstanding.

Parameters:
- TIMEOUT_CYC, 255: maximum bus-busy cycles without bus_ack before the access is aborted; 1..255.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset (rst=0 resets; release is sampled on clk).
- mem_read  in  1  MEM-stage load request (EX/MEM MemRead).
- mem_write  in  1  MEM-stage store request (EX/MEM MemWrite).
- addr  in  32  byte address (EX/MEM ALU result); addr[1:0] ignored.
- wdata  in  32  store data.
- rdata  out  32  load data to MEM/WB.
- stall  out  1  freeze request to the pipeline and hazard logic.
- bus_err  out  1  one-cycle pulse on access timeout.
- bus_req  out  1  backing-memory request.
- bus_we  out  1  1 = write, 0 = read; valid while bus_req=1.
- bus_addr  out  32  word-aligned address {addr[31:2],2'b00}.
- bus_wdata  out  32  write data.
- bus_rdata  in  32  read data; valid when bus_ack=1.
- bus_ack  in  1  one-cycle completion from backing memory.

Behaviour:
- State: FSM {IDLE, W_BUSY, R_BUSY, R_DONE}; write buffer (wb_valid, wb_addr[31:2], wb_data); read register rd_q; 8-bit timeout counter.
- Reset (rst=0, asynchronous): state=IDLE, wb_valid=0, rd_q=0, counter=0. All outputs are 0.
  - A reset mid-transaction aborts it; bus_req drops immediately, with no clock edge required.
- Request priority: if mem_read and mem_write are both 1, treat the access as a write only.
- Write, buffer empty: capture addr/wdata into the buffer on the edge; stall=0 (zero-latency posted store).
- Write, buffer full: stall=1 until the drain completes.
  - stall = wb_valid && !(state==W_BUSY && bus_ack). This is combinational on bus_ack.
  - On the ack edge the buffer clears and the new store is loaded in the same edge; wb_valid stays 1.
- Drain: from IDLE with wb_valid=1 and no higher-priority read, go to W_BUSY.
  - In W_BUSY: bus_req=1, bus_we=1, bus_addr=wb_addr, bus_wdata=wb_data, all held stable until bus_ack.
  - On ack: wb_valid clears (unless reloaded), then go to R_BUSY if a missing read is pending, else IDLE.
- Read hit (wb_valid && wb_addr==addr[31:2]): rdata=wb_data combinationally; stall=0; no bus access.
- Read miss:
  - stall=1 whenever state!=R_DONE.
  - If the buffer is empty, go IDLE→R_BUSY. If the buffer is full, drain it first (W_BUSY), then go to R_BUSY.
  - In R_BUSY: bus_req=1, bus_we=0. On bus_ack: rd_q<=bus_rdata, go to R_DONE.
  - In R_DONE: stall=0, rdata=rd_q. The pipeline advances on the next edge, and the FSM returns to IDLE.
- Minimum read-miss stall: 2 cycles, with ack in the first R_BUSY cycle.
- rdata when neither a hit nor R_DONE: rd_q (don't-care to the pipeline).
- Timeout:
  - The counter clears on entry to a BUSY state and increments each BUSY cycle without ack.
  - When the counter reaches TIMEOUT_CYC: bus_err=1 for one cycle, and bus_req drops.
  - Read timeout: rd_q<=0, go to R_DONE.
  - Write timeout: the buffered store is discarded (wb_valid=0), go to IDLE.
- bus_ack while not BUSY is ignored.
- A write buffered at reset is lost; this is acceptable.

Test Plan:
- Reset: hold rst=0 for 3 cycles with bus_ack=1 → all outputs 0. Assert rst=0 mid-R_BUSY → bus_req=0 within the same cycle.
- Posted store: mem_write, addr=0x10, wdata=0xA5A5A5A5, bus_ack after 3 cycles → stall never 1; bus_req=1, bus_we=1, bus_addr=0x10 for 3 cycles, then wb_valid=0.
- Read hit: store 0x1234 to 0x20, then immediately load 0x22 → rdata=0x1234, stall=0, no bus read issued.
- Read miss behind a pending store:
  - Setup: store to 0x30 pending, then load 0x40; backing memory returns 0xCAFEF00D with ack latency 1 for each access.
  - Required: write completes first, then the read; stall held until R_DONE; MEM/WB captures 0xCAFEF00D.
- Back-to-back stores: 0x50 then 0x54, ack after 2 cycles → second store stalls until the first ack, then loads into the buffer on the same edge; both writes appear on the bus in order.
- Timeout: TIMEOUT_CYC=4, load with bus_ack tied 0 → bus_err pulse after 4 BUSY cycles; rdata=0; stall released the next cycle; FSM back to IDLE.
